// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
// Instruction sequencer for a small accumulator CPU. It loads the program,
// then runs FETCH -> DECODE -> (WAIT) -> EXECUTE for each instruction and
// drives the datapath enables and selects that match the instruction class.
//
// Parameters
//   PROG_LEN   number of program words written during LOAD (2..256)
//   DMEM_WAIT  extra data-memory wait cycles for memory-class ops (0..7)
//
// Optional feature
//   CTRL_SEQ_HALT_EN  when defined, IR=12'h0FF in EXECUTE halts the sequencer
//                     in STOP until reset and drives 'halted'. When undefined,
//                     12'h0FF is an ordinary 0000-class instruction and
//                     'halted' is tied low.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   IR         current instruction register contents
//   SR         status flags (branch condition 0 selects SR[3])
//   PC_E .. PMem_LE  datapath enables and mux selects
//   ALU_Mode   ALU operation select
//   state      current sequencer state
//   load_addr  program-memory write address during LOAD
//   halted     sequencer is in STOP
module ctrl_sequencer #(
    parameter int PROG_LEN  = 10,
    parameter int DMEM_WAIT = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [11:0]                 IR,
    input  logic [3:0]                  SR,
    output logic                        PC_E,
    output logic                        ACC_E,
    output logic                        SR_E,
    output logic                        IR_E,
    output logic                        DR_E,
    output logic                        PMem_E,
    output logic                        DMem_E,
    output logic                        DMem_WE,
    output logic                        ALU_E,
    output logic                        MUX1_Sel,
    output logic                        MUX2_Sel,
    output logic                        PMem_LE,
    output logic [3:0]                  ALU_Mode,
    output logic [2:0]                  state,
    output logic [$clog2(PROG_LEN)-1:0] load_addr,
    output logic                        halted
);

    localparam int AW = $clog2(PROG_LEN);
    localparam logic [AW-1:0] LAST_ADDR = AW'(PROG_LEN - 1);
    // Last value of the wait counter before leaving WAIT (unused when DMEM_WAIT=0)
    localparam logic [2:0] WAIT_LAST = (DMEM_WAIT > 0) ? 3'(DMEM_WAIT - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_EXECUTE = 3'b011,
        ST_STOP    = 3'b100,
        ST_WAIT    = 3'b101
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   load_addr_r;
    logic [2:0]      wait_cnt_r;
    logic            is_mem_s;
    logic            halt_hit_s;

    // Branch condition c tests SR[3-c]
    function automatic logic cond_flag(input logic [3:0] sr, input logic [1:0] cond);
        logic flag;
        case (cond)
            2'd0:    flag = sr[3];
            2'd1:    flag = sr[2];
            2'd2:    flag = sr[1];
            2'd3:    flag = sr[0];
            default: flag = 1'b0;
        endcase
        return flag;
    endfunction

    assign is_mem_s = (IR[11:9] == 3'b001);

`ifdef CTRL_SEQ_HALT_EN
    assign halt_hit_s = (state_r == ST_EXECUTE) && (IR == 12'h0FF);
    assign halted     = (state_r == ST_STOP);
`else
    logic ir_unused_s;
    assign ir_unused_s = ^IR[3:0];
    assign halt_hit_s  = 1'b0;
    assign halted      = 1'b0;
`endif

    assign state     = state_r;
    assign load_addr = load_addr_r;

    // Sequencer state, program load address and data-memory wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_LOAD;
            load_addr_r <= '0;
            wait_cnt_r  <= 3'd0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    // Address holds at the last word once loading is done
                    if (load_addr_r == LAST_ADDR) begin
                        state_r <= ST_FETCH;
                    end else begin
                        load_addr_r <= load_addr_r + AW'(1);
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (is_mem_s && (DMEM_WAIT > 0)) begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= 3'd0;
                    end else begin
                        state_r <= ST_EXECUTE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_r    <= ST_EXECUTE;
                        wait_cnt_r <= 3'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 3'd1;
                    end
                end
                ST_EXECUTE: begin
                    if (halt_hit_s) begin
                        state_r <= ST_STOP;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_STOP: begin
                    state_r <= ST_STOP;
                end
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    // Datapath controls decoded from the registered state and the current IR
    always_comb begin
        PC_E     = 1'b0;
        ACC_E    = 1'b0;
        SR_E     = 1'b0;
        IR_E     = 1'b0;
        DR_E     = 1'b0;
        PMem_E   = 1'b0;
        DMem_E   = 1'b0;
        DMem_WE  = 1'b0;
        ALU_E    = 1'b0;
        MUX1_Sel = 1'b0;
        MUX2_Sel = 1'b0;
        PMem_LE  = 1'b0;
        ALU_Mode = 4'd0;
        case (state_r)
            ST_LOAD: begin
                PMem_LE = 1'b1;
                PMem_E  = 1'b1;
            end
            ST_FETCH: begin
                PMem_E = 1'b1;
                IR_E   = 1'b1;
            end
            ST_DECODE: begin
                if (is_mem_s) begin
                    DMem_E = 1'b1;
                    DR_E   = 1'b1;
                end else begin
                    DMem_E = 1'b0;
                    DR_E   = 1'b0;
                end
            end
            ST_WAIT: begin
                // Memory read stays enabled while waiting on data memory
                DMem_E = 1'b1;
                DR_E   = 1'b1;
            end
            ST_EXECUTE: begin
                if (halt_hit_s) begin
                    PC_E = 1'b0;
                end else begin
                    casez (IR[11:8])
                        4'b0000: begin
                            PC_E     = 1'b1;
                            MUX1_Sel = 1'b1;
                        end
                        4'b0001: begin
                            PC_E = 1'b1;
                        end
                        4'b001?: begin
                            // IR[8]=1 loads the accumulator, IR[8]=0 stores to memory
                            PC_E     = 1'b1;
                            SR_E     = 1'b1;
                            ALU_E    = 1'b1;
                            MUX1_Sel = 1'b1;
                            MUX2_Sel = 1'b1;
                            ACC_E    = IR[8];
                            DMem_E   = ~IR[8];
                            DMem_WE  = ~IR[8];
                            ALU_Mode = IR[7:4];
                        end
                        4'b01??: begin
                            // Branch taken (select 0) when the chosen flag is set
                            PC_E     = 1'b1;
                            MUX1_Sel = ~cond_flag(SR, IR[9:8]);
                        end
                        4'b1???: begin
                            PC_E     = 1'b1;
                            ACC_E    = 1'b1;
                            SR_E     = 1'b1;
                            ALU_E    = 1'b1;
                            MUX1_Sel = 1'b1;
                            ALU_Mode = {1'b0, IR[10:8]};
                        end
                        default: begin
                            PC_E = 1'b0;
                        end
                    endcase
                end
            end
            ST_STOP: begin
                PC_E = 1'b0;
            end
            default: begin
                PC_E = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed testbench for ctrl_sequencer (PROG_LEN=10, DMEM_WAIT=3).
// Enables are packed as {PC_E,ACC_E,SR_E,IR_E,DR_E,PMem_E,DMem_E,DMem_WE,
// ALU_E,MUX1_Sel,MUX2_Sel,PMem_LE} and compared against hand-computed words.
module tb_ctrl_sequencer;

    localparam int PROG_LEN  = 10;
    localparam int DMEM_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] IR;
    logic [3:0]  SR;
    logic        PC_E, ACC_E, SR_E, IR_E, DR_E, PMem_E, DMem_E, DMem_WE;
    logic        ALU_E, MUX1_Sel, MUX2_Sel, PMem_LE;
    logic [3:0]  ALU_Mode;
    logic [2:0]  state;
    logic [3:0]  load_addr;
    logic        halted;
    logic [11:0] en_s;

    int n_total = 0;
    int n_bad   = 0;

    ctrl_sequencer #(.PROG_LEN(PROG_LEN), .DMEM_WAIT(DMEM_WAIT)) dut (
        .clk(clk), .rst(rst), .IR(IR), .SR(SR),
        .PC_E(PC_E), .ACC_E(ACC_E), .SR_E(SR_E), .IR_E(IR_E), .DR_E(DR_E),
        .PMem_E(PMem_E), .DMem_E(DMem_E), .DMem_WE(DMem_WE), .ALU_E(ALU_E),
        .MUX1_Sel(MUX1_Sel), .MUX2_Sel(MUX2_Sel), .PMem_LE(PMem_LE),
        .ALU_Mode(ALU_Mode), .state(state), .load_addr(load_addr), .halted(halted)
    );

    assign en_s = {PC_E, ACC_E, SR_E, IR_E, DR_E, PMem_E, DMem_E, DMem_WE,
                   ALU_E, MUX1_Sel, MUX2_Sel, PMem_LE};

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Ten LOAD cycles with addresses 0..9, then FETCH with the address held
    task automatic do_load;
        for (int i = 0; i < PROG_LEN; i++) begin
            check_val("load_state", 32'(state), 32'd0);
            check_val("load_en", 32'(en_s), 32'h041);
            check_val("load_addr", 32'(load_addr), 32'(i));
            tick;
        end
        check_val("post_load_state", 32'(state), 32'd1);
        check_val("post_load_addr", 32'(load_addr), 32'd9);
        check_val("post_load_le", 32'(PMem_LE), 32'd0);
    endtask

    // Called in FETCH; leaves the bench in EXECUTE after checking it
    task automatic run_instr(input logic [11:0] ir, input logic [3:0] sr, input bit mem,
                             input logic [11:0] exp_ex, input logic [3:0] exp_mode);
        IR = ir;
        SR = sr;
        #1;
        check_val("fetch_state", 32'(state), 32'd1);
        check_val("fetch_en", 32'(en_s), 32'h140);
        tick;
        check_val("decode_state", 32'(state), 32'd2);
        check_val("decode_en", 32'(en_s), mem ? 32'h0A0 : 32'h000);
        if (mem) begin
            for (int i = 0; i < DMEM_WAIT; i++) begin
                tick;
                check_val("wait_state", 32'(state), 32'd5);
                check_val("wait_en", 32'(en_s), 32'h0A0);
            end
        end
        tick;
        check_val("exec_state", 32'(state), 32'd3);
        check_val("exec_en", 32'(en_s), 32'(exp_ex));
        check_val("exec_mode", 32'(ALU_Mode), 32'(exp_mode));
        check_val("exec_halted", 32'(halted), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        IR  = 12'h000;
        SR  = 4'h0;
        tick;
        rst = 1'b0;
        #1;
        check_val("rst_halted", 32'(halted), 32'd0);
        do_load();

        run_instr(12'hB00, 4'h0, 1'b0, 12'hE0C, 4'h3);   // ALU class
        tick;
        check_val("after_alu_en", 32'(en_s), 32'h140);
        run_instr(12'h2A5, 4'h0, 1'b1, 12'hA3E, 4'hA);   // store with waits
        tick;
        run_instr(12'h3C0, 4'h0, 1'b1, 12'hE0E, 4'hC);   // load with waits
        tick;
        run_instr(12'h512, 4'b0100, 1'b0, 12'h800, 4'h0); // branch, flag set
        tick;
        run_instr(12'h512, 4'b0000, 1'b0, 12'h804, 4'h0); // branch, flag clear
        tick;
        run_instr(12'h123, 4'h0, 1'b0, 12'h800, 4'h0);   // 0001 class
        tick;

        // Reset in the middle of WAIT
        IR = 12'h2A5;
        tick;
        tick;
        check_val("mid_wait_state", 32'(state), 32'd5);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check_val("wait_rst_state", 32'(state), 32'd0);
        check_val("wait_rst_addr", 32'(load_addr), 32'd0);
        do_load();
        // A cleared wait counter gives exactly three WAIT cycles again
        run_instr(12'h2A5, 4'h0, 1'b1, 12'hA3E, 4'hA);
        tick;

`ifdef CTRL_SEQ_HALT_EN
        run_instr(12'h0FF, 4'h0, 1'b0, 12'h000, 4'h0);
        tick;
        for (int i = 0; i < 20; i++) begin
            check_val("stop_state", 32'(state), 32'd4);
            check_val("stop_halted", 32'(halted), 32'd1);
            check_val("stop_en", 32'(en_s), 32'h000);
            tick;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check_val("stop_rst_state", 32'(state), 32'd0);
        check_val("stop_rst_halted", 32'(halted), 32'd0);
        check_val("stop_rst_en", 32'(en_s), 32'h041);
`else
        run_instr(12'h0FF, 4'h0, 1'b0, 12'h804, 4'h0);
        tick;
        check_val("no_halt_state", 32'(state), 32'd1);
        check_val("no_halt_halted", 32'(halted), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
